// File: rtl/bsg_fifo_credit_sender.sv
// -----------------------------------------------------------------------------
// bsg_fifo_credit_sender
//
// Sender-side end of a credit-flow link into a remote FIFO of els_p slots.
// Gates an upstream valid stream with locally held credits and mirrors the
// remote FIFO write pointer. The block starts with els_p credits. Each send
// spends one credit. Each credit_i pulse returns credit_decimation_p credits.
//
// Ports
//   clk_i        clock; all state changes on the rising edge
//   reset_n_i    asynchronous reset, active-low
//   v_i          upstream item valid
//   ready_o      a credit is available; a send happens when v_i & ready_o
//   v_o          link valid (v_i & ready_o), combinational
//   credit_i     one pulse = credit_decimation_p remote slots freed
//   wptr_r_o     mirrored remote write pointer (slot taken by the next send)
//   credits_r_o  credits currently held, 0..els_p
//   drained_o    credits_r_o == els_p (remote FIFO believed empty)
//   error_o      sticky credit-overflow flag, cleared only by reset
// -----------------------------------------------------------------------------
module bsg_fifo_credit_sender #(
  parameter int els_p               = 256,
  parameter int credit_decimation_p = 1
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        v_i,
  output logic                        ready_o,
  output logic                        v_o,
  input  logic                        credit_i,
  output logic [$clog2(els_p)-1:0]    wptr_r_o,
  output logic [$clog2(els_p+1)-1:0]  credits_r_o,
  output logic                        drained_o,
  output logic                        error_o
);

  localparam int cnt_w = $clog2(els_p + 1);
  localparam int ptr_w = $clog2(els_p);
  // One spare bit so that an overflowing return is visible before saturation.
  localparam int sum_w = cnt_w + 1;

  localparam logic [sum_w-1:0] max_credits = sum_w'(els_p);
  localparam logic [sum_w-1:0] decim_step  = sum_w'(credit_decimation_p);

  logic [cnt_w-1:0] credits_q, credits_d;
  logic [ptr_w-1:0] wptr_q,    wptr_d;
  logic             error_q,   error_d;

  logic             send;
  logic [sum_w-1:0] credits_sum;

  // ready_o depends only on registered state, so a returned credit becomes
  // usable one cycle after its credit_i pulse.
  assign ready_o     = (credits_q != '0);
  assign send        = v_i & ready_o;
  assign v_o         = send;
  assign drained_o   = (credits_q == max_credits[cnt_w-1:0]);
  assign wptr_r_o    = wptr_q;
  assign credits_r_o = credits_q;
  assign error_o     = error_q;

  // A send is only possible with credits_q >= 1, so the subtraction cannot
  // wrap below zero; only the return can push the sum past els_p.
  assign credits_sum = {1'b0, credits_q} - sum_w'(send)
                     + (credit_i ? decim_step : '0);

  always_comb begin
    // NOTE: every always_comb output gets a default first so that no path
    // leaves it unassigned, which would infer a latch.
    credits_d = credits_sum[cnt_w-1:0];
    error_d   = error_q;
    wptr_d    = wptr_q + ptr_w'(send);

    if (credits_sum > max_credits) begin
      credits_d = max_credits[cnt_w-1:0];
      error_d   = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      credits_q <= max_credits[cnt_w-1:0];
      wptr_q    <= '0;
      error_q   <= 1'b0;
    end else begin
      credits_q <= credits_d;
      wptr_q    <= wptr_d;
      error_q   <= error_d;
    end
  end

  // Simulation-only sanity checks; ignored by synthesis.
  a_decim_divides: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (els_p % credit_decimation_p) == 0)
    else $error("credit_decimation_p must divide els_p");

  a_credit_known: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !$isunknown(credit_i))
    else $error("credit_i is X after reset");

endmodule

// File: tb/tb_bsg_fifo_credit_sender.sv
// -----------------------------------------------------------------------------
// tb_bsg_fifo_credit_sender
//
// Self-checking bench for bsg_fifo_credit_sender. Two instances run side by
// side: dut_a (els_p=256, decimation 1) and dut_b (els_p=16, decimation 4).
// A per-instance reference model tracks credits, pointer and error as plain
// integers and is advanced on every rising edge from the driven inputs.
// Inputs change just after the falling edge; outputs are sampled 1 time unit
// later, well clear of the rising edge.
// -----------------------------------------------------------------------------
module tb_bsg_fifo_credit_sender;

  localparam int els_a = 256;
  localparam int dec_a = 1;
  localparam int els_b = 16;
  localparam int dec_b = 4;

  logic       clk = 1'b0;
  logic       reset_n;

  logic       a_v_i, a_credit_i, a_ready, a_v_o, a_drained, a_err;
  logic [7:0] a_wptr;
  logic [8:0] a_cred;

  logic       b_v_i, b_credit_i, b_ready, b_v_o, b_drained, b_err;
  logic [3:0] b_wptr;
  logic [4:0] b_cred;

  int m_cred [2];
  int m_wptr [2];
  bit m_err  [2];
  int m_els  [2] = '{els_a, els_b};
  int m_dec  [2] = '{dec_a, dec_b};

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  bsg_fifo_credit_sender #(.els_p(els_a), .credit_decimation_p(dec_a)) dut_a (
    .clk_i(clk), .reset_n_i(reset_n), .v_i(a_v_i), .ready_o(a_ready),
    .v_o(a_v_o), .credit_i(a_credit_i), .wptr_r_o(a_wptr),
    .credits_r_o(a_cred), .drained_o(a_drained), .error_o(a_err)
  );

  bsg_fifo_credit_sender #(.els_p(els_b), .credit_decimation_p(dec_b)) dut_b (
    .clk_i(clk), .reset_n_i(reset_n), .v_i(b_v_i), .ready_o(b_ready),
    .v_o(b_v_o), .credit_i(b_credit_i), .wptr_r_o(b_wptr),
    .credits_r_o(b_cred), .drained_o(b_drained), .error_o(b_err)
  );

  // ---------------------------------------------------------------- model
  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_cred[d] = m_els[d];
      m_wptr[d] = 0;
      m_err[d]  = 1'b0;
    end
  endtask

  // One clock of the credit rules: a send needs a credit, a pulse returns
  // the decimation amount, anything above the FIFO depth is an overflow.
  task automatic model_step(input int d, input bit v, input bit c);
    int s;
    int nxt;
    s   = (v && m_cred[d] > 0) ? 1 : 0;
    nxt = m_cred[d] - s + (c ? m_dec[d] : 0);
    if (nxt > m_els[d]) begin
      nxt      = m_els[d];
      m_err[d] = 1'b1;
    end
    m_cred[d] = nxt;
    m_wptr[d] = (m_wptr[d] + s) % m_els[d];
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset_n) begin
      model_step(0, a_v_i, a_credit_i);
      model_step(1, b_v_i, b_credit_i);
    end
    @(negedge clk);
  endtask

  task automatic drive(input bit va, input bit ca, input bit vb, input bit cb);
    a_v_i = va; a_credit_i = ca; b_v_i = vb; b_credit_i = cb;
    #1;
  endtask

  task automatic apply_reset();
    drive(0, 0, 0, 0);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    reset_n = 1'b1;
  endtask

  // Observed / expected output tuples: {ready, v_o, wptr, credits, drained, error}
  function automatic logic [20:0] obs_a();
    return {a_ready, a_v_o, a_wptr, a_cred, a_drained, a_err};
  endfunction

  function automatic logic [20:0] exp_a();
    logic r;
    r = (m_cred[0] != 0);
    return {r, a_v_i & r, 8'(m_wptr[0]), 9'(m_cred[0]), m_cred[0] == els_a, m_err[0]};
  endfunction

  function automatic logic [12:0] obs_b();
    return {b_ready, b_v_o, b_wptr, b_cred, b_drained, b_err};
  endfunction

  function automatic logic [12:0] exp_b();
    logic r;
    r = (m_cred[1] != 0);
    return {r, b_v_i & r, 4'(m_wptr[1]), 5'(m_cred[1]), m_cred[1] == els_b, m_err[1]};
  endfunction

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    a_v_i = 0; a_credit_i = 0; b_v_i = 0; b_credit_i = 0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if ({a_cred, a_wptr, a_err, a_ready, a_drained} !== {9'd256, 8'd0, 1'b0, 1'b1, 1'b1})
      $display("FAIL reset_a: cred=%0d wptr=%0d err=%b rdy=%b drn=%b, want 256/0/0/1/1",
               a_cred, a_wptr, a_err, a_ready, a_drained);
    else n_pass++;
    n_checks++;
    if ({b_cred, b_wptr, b_err, b_ready, b_drained} !== {5'd16, 4'd0, 1'b0, 1'b1, 1'b1})
      $display("FAIL reset_b: cred=%0d wptr=%0d err=%b rdy=%b drn=%b, want 16/0/0/1/1",
               b_cred, b_wptr, b_err, b_ready, b_drained);
    else n_pass++;
    // v_o must follow v_i with no latency out of reset.
    a_v_i = 1'b1;
    #1;
    n_checks++;
    if (a_v_o !== 1'b1) $display("FAIL reset_vo: v_o=%b want 1", a_v_o);
    else n_pass++;
    a_v_i = 1'b0;
    @(negedge clk);
    model_reset();
    reset_n = 1'b1;
  endtask

  task automatic test_fill();
    int pulses;
    apply_reset();
    pulses = 0;
    for (int i = 0; i < els_a; i++) begin
      drive(1, 0, 0, 0);
      if (a_v_o === 1'b1) pulses++;
      tick();
    end
    n_checks++;
    if (pulses != els_a) $display("FAIL fill_pulses: got %0d want %0d", pulses, els_a);
    else n_pass++;
    drive(1, 0, 0, 0);
    n_checks++;
    if ({a_ready, a_v_o, a_cred, a_wptr, a_drained} !== {1'b0, 1'b0, 9'd0, 8'd0, 1'b0})
      $display("FAIL fill_empty: rdy=%b vo=%b cred=%0d wptr=%0d drn=%b want 0/0/0/0/0",
               a_ready, a_v_o, a_cred, a_wptr, a_drained);
    else n_pass++;
    tick();
  endtask

  task automatic test_credit_return();
    drive(0, 1, 0, 0);
    n_checks++;
    if (a_ready !== 1'b0) $display("FAIL ret_same_cycle: rdy=%b want 0", a_ready);
    else n_pass++;
    tick();
    drive(1, 0, 0, 0);
    n_checks++;
    if ({a_ready, a_v_o} !== 2'b11) $display("FAIL ret_next_cycle: rdy/vo=%b want 11", {a_ready, a_v_o});
    else n_pass++;
    tick();
    drive(0, 0, 0, 0);
    n_checks++;
    if ({a_cred, a_wptr} !== {9'd0, 8'd1})
      $display("FAIL ret_send: cred=%0d wptr=%0d want 0/1", a_cred, a_wptr);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    drive(0, 1, 0, 0);
    tick();
    drive(1, 1, 0, 0);
    n_checks++;
    if ({a_cred, a_v_o} !== {9'd1, 1'b1}) $display("FAIL simul_pre: cred=%0d vo=%b want 1/1", a_cred, a_v_o);
    else n_pass++;
    tick();
    drive(0, 0, 0, 0);
    n_checks++;
    if ({a_cred, a_wptr, a_err} !== {9'd1, 8'd2, 1'b0})
      $display("FAIL simul_post: cred=%0d wptr=%0d err=%b want 1/2/0", a_cred, a_wptr, a_err);
    else n_pass++;
  endtask

  task automatic test_overflow();
    apply_reset();
    drive(0, 1, 0, 0);
    tick();
    drive(0, 0, 0, 0);
    n_checks++;
    if ({a_cred, a_err} !== {9'd256, 1'b1}) $display("FAIL ovf: cred=%0d err=%b want 256/1", a_cred, a_err);
    else n_pass++;
    for (int i = 0; i < 100; i++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 2) == 0, 0, 0);
      n_checks++;
      if (obs_a() !== exp_a() || a_err !== 1'b1)
        $display("FAIL ovf_sticky[%0d]: got %h want %h", i, obs_a(), exp_a());
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_decimation();
    apply_reset();
    for (int i = 0; i < els_b; i++) begin
      drive(0, 0, 1, 0);
      tick();
    end
    drive(0, 0, 0, 0);
    n_checks++;
    if ({b_cred, b_ready, b_wptr} !== {5'd0, 1'b0, 4'd0})
      $display("FAIL dec_empty: cred=%0d rdy=%b wptr=%0d want 0/0/0", b_cred, b_ready, b_wptr);
    else n_pass++;
    for (int p = 1; p <= 4; p++) begin
      drive(0, 0, 0, 1);
      tick();
      drive(0, 0, 0, 0);
      n_checks++;
      if ({b_cred, b_drained, b_err} !== {5'(4 * p), p == 4, 1'b0})
        $display("FAIL dec_pulse%0d: cred=%0d drn=%b err=%b want %0d/%b/0",
                 p, b_cred, b_drained, b_err, 4 * p, p == 4);
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    drive(0, 1, 0, 0);
    tick();
    for (int i = 0; i < 219; i++) begin
      drive(1, 0, 0, 0);
      tick();
    end
    drive(1, 0, 0, 0);
    n_checks++;
    if ({a_cred, a_wptr, a_err} !== {9'd37, 8'd219, 1'b1})
      $display("FAIL async_pre: cred=%0d wptr=%0d err=%b want 37/219/1", a_cred, a_wptr, a_err);
    else n_pass++;
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({a_cred, a_wptr, a_err, a_ready, a_drained, a_v_o} !== {9'd256, 8'd0, 1'b0, 1'b1, 1'b1, 1'b1})
      $display("FAIL async_reset: cred=%0d wptr=%0d err=%b rdy=%b drn=%b vo=%b want 256/0/0/1/1/1",
               a_cred, a_wptr, a_err, a_ready, a_drained, a_v_o);
    else n_pass++;
    @(negedge clk);
    model_reset();
    reset_n = 1'b1;
  endtask

  task automatic test_random();
    int pv;
    int pc;
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      // Phases alternate between draining, balanced and credit-flooding traffic.
      case ((i / 250) % 3)
        0:       begin pv = 90; pc = 20; end
        1:       begin pv = 50; pc = 50; end
        default: begin pv = 20; pc = 70; end
      endcase
      drive($urandom_range(0, 99) < pv, $urandom_range(0, 99) < pc,
            $urandom_range(0, 99) < pv, $urandom_range(0, 99) < pc / 3);
      n_checks++;
      if (obs_a() !== exp_a()) $display("FAIL rand_a[%0d]: got %h want %h", i, obs_a(), exp_a());
      else n_pass++;
      n_checks++;
      if (obs_b() !== exp_b()) $display("FAIL rand_b[%0d]: got %h want %h", i, obs_b(), exp_b());
      else n_pass++;
      tick();
    end
  endtask

  // ---------------------------------------------------------------- main
  initial begin
    test_reset();
    test_fill();
    test_credit_return();
    test_simultaneous();
    test_overflow();
    test_decimation();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "timeout");
  end

endmodule
